// File: rtl/video_pkg.sv
// Shared constants for the video block: default VGA timing, colour width,
// and the grid rule used by the test pattern.
package video_pkg;

    localparam int HDISP_DEF         = 800;
    localparam int VDISP_DEF         = 480;
    localparam int HFP_DEF           = 40;
    localparam int HPULSE_DEF        = 48;
    localparam int HBP_DEF           = 40;
    localparam int VFP_DEF           = 13;
    localparam int VPULSE_DEF        = 3;
    localparam int VBP_DEF           = 29;
    localparam int HEARTBEAT_DIV_DEF = 25_000_000;

    localparam int COLOR_W = 8;

    typedef logic [COLOR_W-1:0] color_t;

    // A grid line falls on every 16th column and every 16th row.
    function automatic logic grid_on(input logic [3:0] x_lo, input logic [3:0] y_lo);
        return (x_lo == 4'd0) || (y_lo == 4'd0);
    endfunction

endpackage

// File: rtl/video_top_vga_timing.sv
// VGA raster counters with combinational sync, active-area and pixel
// coordinate decode; the top registers these to align them with colour.
module vga_timing
    import video_pkg::*;
#(
    parameter int HDISP  = HDISP_DEF,
    parameter int VDISP  = VDISP_DEF,
    parameter int HFP    = HFP_DEF,
    parameter int HPULSE = HPULSE_DEF,
    parameter int HBP    = HBP_DEF,
    parameter int VFP    = VFP_DEF,
    parameter int VPULSE = VPULSE_DEF,
    parameter int VBP    = VBP_DEF,
    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP,
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP,
    localparam int HW     = $clog2(HTOTAL),
    localparam int VW     = $clog2(VTOTAL)
) (
    input  logic          clk,
    input  logic          nrst,
    output logic          hs,
    output logic          vs,
    output logic          active,
    output logic          vs_start,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y
);

    localparam logic [HW-1:0] H_LAST    = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT     = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_LAST    = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT     = VW'(VFP + VPULSE + VBP);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Stage p0: decode straight from the counters
    assign hs       = !((hcnt >= H_SYNC_LO) && (hcnt < H_SYNC_HI));
    assign vs       = !((vcnt >= V_SYNC_LO) && (vcnt < V_SYNC_HI));
    assign active   = (hcnt >= H_ACT) && (vcnt >= V_ACT);
    assign vs_start = (vcnt == V_SYNC_LO) && (hcnt == '0);
    assign x        = hcnt - H_ACT;
    assign y        = vcnt - V_ACT;

endmodule

// File: rtl/video_top.sv
// Board-level video block: VGA timing, white grid test pattern on black,
// status LEDs and auxiliary-oscillator select.
module video_top
    import video_pkg::*;
#(
    parameter int HDISP         = HDISP_DEF,
    parameter int VDISP         = VDISP_DEF,
    parameter int HFP           = HFP_DEF,
    parameter int HPULSE        = HPULSE_DEF,
    parameter int HBP           = HBP_DEF,
    parameter int VFP           = VFP_DEF,
    parameter int VPULSE        = VPULSE_DEF,
    parameter int VBP           = VBP_DEF,
    parameter int HEARTBEAT_DIV = HEARTBEAT_DIV_DEF
) (
    input  logic               fpga_CLK,
    input  logic               fpga_NRST,
    input  logic               fpga_SW0,
    input  logic               fpga_SW1,
    output logic               fpga_LEDR0,
    output logic               fpga_LEDR1,
    output logic               fpga_LEDR2,
    output logic               fpga_LEDR3,
    output logic               fpga_SEL_CLK_AUX,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK,
    output logic               VGA_SYNC,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int HB_W   = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_DIV - 1);

    logic          hs;
    logic          vs;
    logic          active;
    logic          vs_start;
    logic [HW-1:0] x;
    logic [VW-1:0] y;

    vga_timing #(
        .HDISP  (HDISP),
        .VDISP  (VDISP),
        .HFP    (HFP),
        .HPULSE (HPULSE),
        .HBP    (HBP),
        .VFP    (VFP),
        .VPULSE (VPULSE),
        .VBP    (VBP)
    ) u_timing (
        .clk      (fpga_CLK),
        .nrst     (fpga_NRST),
        .hs       (hs),
        .vs       (vs),
        .active   (active),
        .vs_start (vs_start),
        .x        (x),
        .y        (y)
    );

    // Only the low nibble of each coordinate matters to the grid.
    logic unused_xy;
    assign unused_xy = &{1'b0, x[HW-1:4], y[VW-1:4]};

    logic            hs_p1;
    logic            vs_p1;
    logic            vld_p1;
    color_t          pix_p1;
    logic            led0_p1;
    logic            led1_p1;
    logic            led2_p1;
    logic            led3_p1;
    logic            sel_aux_p1;
    logic [HB_W-1:0] hb_cnt;

    // Stage p1: registered sync, blank, colour and board I/O
    always_ff @(posedge fpga_CLK) begin
        if (!fpga_NRST) begin
            hs_p1      <= 1'b1;
            vs_p1      <= 1'b1;
            vld_p1     <= 1'b0;
            pix_p1     <= '0;
            led0_p1    <= 1'b0;
            led1_p1    <= 1'b0;
            led2_p1    <= 1'b0;
            led3_p1    <= 1'b0;
            sel_aux_p1 <= 1'b0;
            hb_cnt     <= '0;
        end else begin
            hs_p1      <= hs;
            vs_p1      <= vs;
            vld_p1     <= active;
            pix_p1     <= (active && grid_on(x[3:0], y[3:0])) ? '1 : '0;
            led0_p1    <= fpga_SW0;
            led3_p1    <= fpga_SW1;
            sel_aux_p1 <= fpga_SW1;
            if (vs_start) begin
                led2_p1 <= ~led2_p1;
            end
            if (hb_cnt == HB_LAST) begin
                hb_cnt  <= '0;
                led1_p1 <= ~led1_p1;
            end else begin
                hb_cnt <= hb_cnt + 1'b1;
            end
        end
    end

    // The DAC latches on the falling edge of fpga_CLK, mid-way through each pixel.
    assign VGA_CLK          = ~fpga_CLK;
    assign VGA_HS           = hs_p1;
    assign VGA_VS           = vs_p1;
    assign VGA_BLANK        = vld_p1;
    assign VGA_SYNC         = 1'b0;
    assign VGA_R            = pix_p1;
    assign VGA_G            = pix_p1;
    assign VGA_B            = pix_p1;
    assign fpga_LEDR0       = led0_p1;
    assign fpga_LEDR1       = led1_p1;
    assign fpga_LEDR2       = led2_p1;
    assign fpga_LEDR3       = led3_p1;
    assign fpga_SEL_CLK_AUX = sel_aux_p1;

endmodule

// File: tb/tb_video_top.sv
// Scoreboard bench for video_top at a reduced 160x90 raster: a time-based
// reference model predicts every output cycle, plus a captured-screen check.
module tb_video_top;

    localparam int HD    = 160;
    localparam int VD    = 90;
    localparam int HT    = 288;
    localparam int VT    = 135;
    localparam int FRAME = HT * VT;
    localparam int HOFF  = 128;
    localparam int VOFF  = 45;
    localparam int HBD   = 10;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       sw0 = 1'b0;
    logic       sw1 = 1'b0;
    logic       led0, led1, led2, led3, sel_aux;
    logic       vga_clk, vga_hs, vga_vs, vga_blank, vga_sync;
    logic [7:0] vga_r, vga_g, vga_b;

    always #10 clk = ~clk;

    video_top #(
        .HDISP         (HD),
        .VDISP         (VD),
        .HEARTBEAT_DIV (HBD)
    ) dut (
        .fpga_CLK         (clk),
        .fpga_NRST        (nrst),
        .fpga_SW0         (sw0),
        .fpga_SW1         (sw1),
        .fpga_LEDR0       (led0),
        .fpga_LEDR1       (led1),
        .fpga_LEDR2       (led2),
        .fpga_LEDR3       (led3),
        .fpga_SEL_CLK_AUX (sel_aux),
        .VGA_CLK          (vga_clk),
        .VGA_HS           (vga_hs),
        .VGA_VS           (vga_vs),
        .VGA_BLANK        (vga_blank),
        .VGA_SYNC         (vga_sync),
        .VGA_R            (vga_r),
        .VGA_G            (vga_g),
        .VGA_B            (vga_b)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
        logic [3:0]  led;
        logic        sel;
        logic        sync;
        logic        vclk;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   k = 0;
    int   cyc = 0;

    // Reference: k = number of clock edges since reset release; the raster
    // position, heartbeat phase and VS-start count all follow from k alone.
    function automatic obs_t model(input bit rst_n, input int kk, input bit s0, input bit s1);
        obs_t o;
        int   h, v, px, py, starts;
        bit   act;
        o = '0;
        if (!rst_n) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
            return o;
        end
        h  = kk % HT;
        v  = (kk / HT) % VT;
        o.hs = !(h >= 40 && h < 88);
        o.vs = !(v >= 13 && v < 16);
        act = (h >= HOFF) && (v >= VOFF);
        o.blank = act;
        px = h - HOFF;
        py = v - VOFF;
        if (act && ((px % 16) == 0 || (py % 16) == 0)) o.rgb = 24'hFFFFFF;
        o.led[0] = s0;
        o.led[3] = s1;
        o.sel    = s1;
        o.led[1] = 1'(((kk + 1) / HBD) % 2);
        starts = (kk >= 13 * HT) ? (kk - 13 * HT) / FRAME + 1 : 0;
        o.led[2] = 1'(starts % 2);
        return o;
    endfunction

    task automatic cycle(input bit r, input bit s0, input bit s1);
        @(negedge clk);
        nrst = r;
        sw0  = s0;
        sw1  = s1;
        exp_q.push_back(model(r, k, s0, s1));
        if (!r) k = 0;
        else    k = k + 1;
    endtask

    // Screen model: raster-ordered capture of the first full frame.
    bit   screen [HD*VD];
    int   cap_state = 0;
    int   pix = 0;
    bit   prev_vs = 1'b1;
    obs_t e_obs, a_obs;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            if (exp_q.size() > 0) begin
                e_obs = exp_q.pop_front();
                a_obs.hs    = vga_hs;
                a_obs.vs    = vga_vs;
                a_obs.blank = vga_blank;
                a_obs.rgb   = {vga_r, vga_g, vga_b};
                a_obs.led   = {led3, led2, led1, led0};
                a_obs.sel   = sel_aux;
                a_obs.sync  = vga_sync;
                a_obs.vclk  = vga_clk;
                checks = checks + 1;
                if (a_obs === e_obs) passes = passes + 1;
                else $display("FAIL cycle %0d outputs: got %h expected %h", cyc, a_obs, e_obs);

                if (prev_vs && !a_obs.vs) begin
                    if (cap_state == 0) begin
                        cap_state = 1;
                        pix = 0;
                    end else if (cap_state == 1) begin
                        cap_state = 2;
                        checks = checks + 1;
                        if (pix == HD * VD) passes = passes + 1;
                        else $display("FAIL frame_pixels: got %0d expected %0d", pix, HD * VD);
                    end
                end
                if (cap_state == 1 && a_obs.blank) begin
                    if (pix < HD * VD) screen[pix] = (a_obs.rgb == 24'hFFFFFF);
                    pix = pix + 1;
                end
                prev_vs = a_obs.vs;
            end
        end
    end

    task automatic check_pixel(input int px, input int py, input bit white);
        checks = checks + 1;
        if (cap_state == 2 && screen[py * HD + px] == white) passes = passes + 1;
        else $display("FAIL pixel(%0d,%0d): got white=%0d expected white=%0d (capture state %0d)",
                      px, py, screen[py * HD + px], white, cap_state);
    endtask

    bit s0 = 1'b0;
    bit s1 = 1'b0;

    initial begin
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        // Deterministic switch steps first, then random toggling.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        s0 = 1'b1;
        s1 = 1'b1;
        for (int i = 0; i < 43000; i++) begin
            if ($urandom_range(0, 99) < 3) s0 = ~s0;
            if ($urandom_range(0, 99) < 3) s1 = ~s1;
            cycle(1'b1, s0, s1);
        end
        // Mid-frame reset of random length, then a few lines of restart.
        for (int i = 0; i < int'($urandom_range(2, 5)); i++) cycle(1'b0, s0, s1);
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 99) < 3) s0 = ~s0;
            cycle(1'b1, s0, s1);
        end
        repeat (4) @(posedge clk);
        #5;
        checks = checks + 1;
        if (exp_q.size() == 0) passes = passes + 1;
        else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());

        check_pixel(0, 0, 1'b1);
        check_pixel(16, 5, 1'b1);
        check_pixel(3, 32, 1'b1);
        check_pixel(1, 1, 1'b0);
        check_pixel(17, 17, 1'b0);
        check_pixel(159, 89, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
